// File: rtl/mux_accum_engine.sv
`default_nettype none
// ============================================================================
// Module   : mux_accum_engine
// Brief    : Row buffer streamed through a pipelined adder tree into an
//            accumulator, with start/done handshake and rounded LED view.
// Revision : 1.0
// ============================================================================
module mux_accum_engine #(
    parameter int LANES     = 8,
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 32,
    parameter int ACC_W     = 32,
    parameter int OUT_SHIFT = 8,
    parameter int ROUND     = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [LANES*WIDTH-1:0]     wr_data,
    input  logic                       start,
    input  logic [$clog2(DEPTH):0]     len,
    output logic                       busy,
    output logic                       done,
    output logic [ACC_W-1:0]           result,
    output logic [7:0]                 led
);

    localparam int c_aw        = $clog2(DEPTH);
    localparam int c_tree_lvls = $clog2(LANES);
    localparam int c_cw        = $clog2(c_tree_lvls + 2);
    localparam int c_tree_w    = WIDTH + c_tree_lvls;
    localparam logic [ACC_W-1:0] c_round =
        (ROUND != 0 && OUT_SHIFT > 0) ? (ACC_W'(1) << (OUT_SHIFT - 1)) : '0;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [c_aw-1:0]        r_rd_ptr;
    logic [c_aw-1:0]        r_len_m1;
    logic [c_aw-1:0]        w_len_m1;
    logic [c_aw:0]          w_len_dec;
    logic [c_cw-1:0]        r_drain_cnt;
    logic [ACC_W-1:0]       r_acc;
    logic [ACC_W-1:0]       r_result;
    logic                   r_busy;
    logic                   r_done;
    logic [LANES*WIDTH-1:0] r_mem [DEPTH];
    logic [LANES*WIDTH-1:0] w_row;
    logic [c_tree_w-1:0]    w_tree;
    logic                   w_tree_vld;
    logic [ACC_W+OUT_SHIFT+7:0] w_res_ext;

    // Out-of-range lengths (0 or beyond the buffer) mean "whole buffer".
    always_comb begin
        w_len_dec = len - 1'b1;
        if (len == '0 || len > (c_aw+1)'(DEPTH))
            w_len_m1 = c_aw'(DEPTH - 1);
        else
            w_len_m1 = w_len_dec[c_aw-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (r_rd_ptr == r_len_m1) w_state_nxt = S_DRAIN;
            S_DRAIN: if (r_drain_cnt == c_cw'(c_tree_lvls)) w_state_nxt = S_FIN;
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Buffer is deliberately not reset; writes are only honoured while idle.
    always_ff @(posedge clk) begin
        if (wr_en && r_state == S_IDLE)
            r_mem[wr_addr] <= wr_data;
    end

    assign w_row = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr    <= '0;
            r_len_m1    <= '0;
            r_drain_cnt <= '0;
            r_acc       <= '0;
            r_result    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_tree_vld)
                r_acc <= r_acc + ACC_W'(w_tree);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy   <= 1'b1;
                        r_acc    <= '0;
                        r_rd_ptr <= '0;
                        r_len_m1 <= w_len_m1;
                    end
                end
                S_RUN: begin
                    r_rd_ptr    <= r_rd_ptr + 1'b1;
                    r_drain_cnt <= '0;
                end
                S_DRAIN: r_drain_cnt <= r_drain_cnt + 1'b1;
                S_FIN: begin
                    r_result <= r_acc + c_round;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Level 0 captures the selected row; level k holds LANES>>k partial sums.
    for (genvar k = 0; k <= c_tree_lvls; k++) begin : g_lvl
        localparam int c_n = LANES >> k;
        localparam int c_w = WIDTH + k;
        logic [c_n*c_w-1:0] r_data;
        logic               r_vld;

        if (k == 0) begin : g_s0
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld  <= 1'b0;
                    r_data <= '0;
                end else begin
                    r_vld <= (r_state == S_RUN);
                    if (r_state == S_RUN)
                        r_data <= w_row;
                end
            end
        end else begin : g_sum
            localparam int c_pw = WIDTH + k - 1;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld  <= 1'b0;
                    r_data <= '0;
                end else begin
                    r_vld <= g_lvl[k-1].r_vld;
                    for (int j = 0; j < c_n; j++)
                        r_data[j*c_w +: c_w] <=
                            {1'b0, g_lvl[k-1].r_data[(2*j)*c_pw +: c_pw]} +
                            {1'b0, g_lvl[k-1].r_data[(2*j+1)*c_pw +: c_pw]};
                end
            end
        end
    end

    assign w_tree     = g_lvl[c_tree_lvls].r_data;
    assign w_tree_vld = g_lvl[c_tree_lvls].r_vld;

    // Zero-extend so the LED slice stays legal when ACC_W is narrow.
    assign w_res_ext = {{(OUT_SHIFT+8){1'b0}}, r_result};
    assign led       = w_res_ext[OUT_SHIFT +: 8];
    assign result    = r_result;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire
